// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter with an internal 4:1 data mux feeding one valid/ready consumer.
// Optional per-requester grant counters are enabled by defining MUX4_ARB_STATS_EN.
module mux4_rr_arbiter #(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [3:0]            req_valid,
  input  logic [4*DATA_W-1:0]   req_data,
  output logic [3:0]            req_ready,
  output logic                  out_valid,
  output logic [DATA_W-1:0]     out_data,
  input  logic                  out_ready,
  output logic [1:0]            sel,
  output logic                  busy,
  output logic [63:0]           stat_cnt
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic [1:0]        sel_r;
  logic [1:0]        sel_nxt_s;
  logic [1:0]        last_grant_r;
  logic [1:0]        last_grant_nxt_s;
  logic              busy_s;
  logic              sel_valid_s;
  logic              xfer_s;
  logic [2:0]        idle_pick_s;
  logic [2:0]        busy_pick_s;
  logic [DATA_W-1:0] word_s [4];

  // Returns {found, index}: first set bit of mask scanning upward from start with wrap.
  function automatic logic [2:0] rr_pick(input logic [3:0] mask, input logic [1:0] start);
    logic [1:0] idx;
    rr_pick = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      idx = start + i[1:0];
      if (mask[idx]) begin
        rr_pick = {1'b1, idx};
      end else begin
        rr_pick = rr_pick;
      end
    end
  endfunction

  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    onehot4 = 4'b0001 << idx;
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_word
    assign word_s[g] = req_data[g*DATA_W +: DATA_W];
  end

  // Handshake and mux outputs, passed straight through from the live inputs.
  always_comb begin
    busy_s      = (state_r == ST_BUSY);
    sel_valid_s = req_valid[sel_r];
    out_valid   = busy_s & sel_valid_s;
    xfer_s      = out_valid & out_ready;
    if (xfer_s) begin
      req_ready = onehot4(sel_r);
    end else begin
      req_ready = 4'b0000;
    end
    if (busy_s) begin
      out_data = word_s[sel_r];
    end else begin
      out_data = {DATA_W{1'b0}};
    end
    idle_pick_s = rr_pick(req_valid, last_grant_r + 2'd1);
    busy_pick_s = rr_pick(req_valid & ~onehot4(sel_r), sel_r + 2'd1);
  end

  // Next-state logic: the current owner is masked out on transfer so it cannot hog the mux.
  always_comb begin
    state_nxt_s      = state_r;
    sel_nxt_s        = sel_r;
    last_grant_nxt_s = last_grant_r;
    case (state_r)
      ST_IDLE: begin
        if (idle_pick_s[2]) begin
          sel_nxt_s   = idle_pick_s[1:0];
          state_nxt_s = ST_BUSY;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (xfer_s) begin
          last_grant_nxt_s = sel_r;
          if (busy_pick_s[2]) begin
            sel_nxt_s   = busy_pick_s[1:0];
            state_nxt_s = ST_BUSY;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else if (!sel_valid_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_BUSY;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, grant and priority-pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      sel_r        <= 2'b00;
      last_grant_r <= 2'b11;
    end else begin
      state_r      <= state_nxt_s;
      sel_r        <= sel_nxt_s;
      last_grant_r <= last_grant_nxt_s;
    end
  end

  assign sel  = sel_r;
  assign busy = busy_s;

`ifdef MUX4_ARB_STATS_EN
  logic [15:0] cnt_r [4];

  // Saturating per-requester transfer counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        cnt_r[i] <= 16'h0000;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (req_ready[i] && (cnt_r[i] != 16'hFFFF)) begin
          cnt_r[i] <= cnt_r[i] + 16'd1;
        end else begin
          cnt_r[i] <= cnt_r[i];
        end
      end
    end
  end

  assign stat_cnt = {cnt_r[3], cnt_r[2], cnt_r[1], cnt_r[0]};
`else
  assign stat_cnt = 64'h0;
`endif

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter: a scoreboard queue holds expected transfers,
// popped by a negedge monitor whenever the DUT accepts a word.
module tb_mux4_rr_arbiter;

  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [3:0]      req_valid;
  logic [4*DW-1:0] req_data;
  logic [3:0]      req_ready;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic            out_ready;
  logic [1:0]      sel;
  logic            busy;
  logic [63:0]     stat_cnt;

  typedef struct {
    logic [1:0]    idx;
    logic [DW-1:0] data;
  } xfer_t;

  xfer_t       sb_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_cnt [4];

  mux4_rr_arbiter #(.DATA_W(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .sel       (sel),
    .busy      (busy),
    .stat_cnt  (stat_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_words(input logic [DW-1:0] base);
    for (int k = 0; k < 4; k++) req_data[k*DW +: DW] = base + DW'(k);
  endtask

  task automatic push(input logic [1:0] i);
    xfer_t t;
    t.idx  = i;
    t.data = req_data[int'(i)*DW +: DW];
    sb_q.push_back(t);
  endtask

  function automatic logic [63:0] exp_stat();
`ifdef MUX4_ARB_STATS_EN
    return {exp_cnt[3], exp_cnt[2], exp_cnt[1], exp_cnt[0]};
`else
    return 64'h0;
`endif
  endfunction

  // Monitor: every accepted word must match the head of the scoreboard.
  always @(negedge clk) begin : monitor
    xfer_t t;
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) exp_cnt[k] = 16'h0000;
    end else if (|req_ready) begin
      checks++;
      assert (sb_q.size() > 0) else begin
        errors++;
        $error("FAIL sb_unexpected observed=%0h expected=none", req_ready);
      end
      if (sb_q.size() > 0) begin
        t = sb_q.pop_front();
        chk("sb_ready", {60'd0, req_ready}, {60'd0, 4'b0001 << t.idx});
        chk("sb_data", {32'd0, out_data}, {32'd0, t.data});
        if (exp_cnt[t.idx] != 16'hFFFF) exp_cnt[t.idx] = exp_cnt[t.idx] + 16'd1;
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    req_valid = 4'b0000;
    req_data  = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_sel", {62'd0, sel}, 64'd0);
    chk("rst_ready", {60'd0, req_ready}, 64'd0);
    chk("rst_stat", stat_cnt, 64'd0);

    // Single request from requester 0
    set_words(32'h1000_0000);
    req_data[DW-1:0] = 32'hDEADBEEF;
    req_valid = 4'b0001;
    out_ready = 1'b1;
    push(2'd0);
    cyc();
    chk("t1_sel", {62'd0, sel}, 64'd0);
    chk("t1_valid", {63'd0, out_valid}, 64'd1);
    chk("t1_data", {32'd0, out_data}, 64'hDEADBEEF);
    chk("t1_ready", {60'd0, req_ready}, 64'h1);
    chk("t1_busy", {63'd0, busy}, 64'd1);
    cyc();
    req_valid = 4'b0000;
    chk("t1_idle", {63'd0, busy}, 64'd0);
    chk("t1_stat", stat_cnt, exp_stat());

    // Restore reset priority before the rotation test
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;

    // All four requesting: rotation 0,1,2,3,0 at one word per cycle
    set_words(32'hC0DE_0000);
    req_valid = 4'b1111;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) push(2'(k % 4));
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("t2_sel", {62'd0, sel}, 64'(k % 4));
      chk("t2_ready", {60'd0, req_ready}, 64'(4'b0001 << (k % 4)));
      if (k == 4) req_valid = 4'b0001;
    end
    cyc();
    req_valid = 4'b0000;
    chk("t2_idle", {63'd0, busy}, 64'd0);

    // Grant to 2 stalled by consumer, then released with 3 still pending
    set_words(32'h5A5A_0000);
    req_valid = 4'b1100;
    out_ready = 1'b0;
    cyc();
    for (int j = 0; j < 5; j++) begin
      chk("t3_sel", {62'd0, sel}, 64'd2);
      chk("t3_valid", {63'd0, out_valid}, 64'd1);
      chk("t3_ready", {60'd0, req_ready}, 64'd0);
      chk("t3_data", {32'd0, out_data}, 64'h5A5A_0002);
      cyc();
    end
    push(2'd2);
    push(2'd3);
    out_ready = 1'b1;
    #1;
    chk("t3_accept", {60'd0, req_ready}, 64'h4);
    cyc();
    chk("t3_next_sel", {62'd0, sel}, 64'd3);
    chk("t3_next_ready", {60'd0, req_ready}, 64'h8);
    req_valid = 4'b1000;
    cyc();
    req_valid = 4'b0000;
    chk("t3_idle", {63'd0, busy}, 64'd0);

    // Granted requester withdraws before acceptance
    set_words(32'h7777_0000);
    req_valid = 4'b0010;
    out_ready = 1'b0;
    cyc();
    chk("t4_sel", {62'd0, sel}, 64'd1);
    chk("t4_valid", {63'd0, out_valid}, 64'd1);
    req_valid = 4'b0000;
    out_ready = 1'b1;
    #1;
    chk("t4_drop_valid", {63'd0, out_valid}, 64'd0);
    chk("t4_drop_ready", {60'd0, req_ready}, 64'd0);
    cyc();
    chk("t4_idle", {63'd0, busy}, 64'd0);
    chk("t4_stat", stat_cnt, exp_stat());
    // Last grant is still 3, so requester 1 beats 2
    req_valid = 4'b0110;
    out_ready = 1'b0;
    cyc();
    chk("t4_lastgrant", {62'd0, sel}, 64'd1);

    // Asynchronous reset in the middle of a BUSY cycle
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_busy", {63'd0, busy}, 64'd0);
    chk("t5_valid", {63'd0, out_valid}, 64'd0);
    chk("t5_sel", {62'd0, sel}, 64'd0);
    chk("t5_ready", {60'd0, req_ready}, 64'd0);
    #2;
    rst_n = 1'b1;
    set_words(32'h1234_0000);
    req_valid = 4'b1111;
    out_ready = 1'b1;
    push(2'd0);
    cyc();
    chk("t5_sel_after", {62'd0, sel}, 64'd0);
    chk("t5_ready_after", {60'd0, req_ready}, 64'h1);
    req_valid = 4'b0001;
    cyc();
    req_valid = 4'b0000;
    chk("t5_idle", {63'd0, busy}, 64'd0);
    chk("t5_stat", stat_cnt, exp_stat());

`ifdef MUX4_ARB_STATS_EN
    // Counter saturation from requester 1 alone
    set_words(32'hABCD_0000);
    req_valid = 4'b0010;
    out_ready = 1'b1;
    for (int n = 0; n < 65540; n++) begin
      push(2'd1);
      cyc();
      cyc();
    end
    req_valid = 4'b0000;
    cyc();
    chk("t6_sat1", {48'd0, stat_cnt[31:16]}, 64'hFFFF);
    chk("t6_stat", stat_cnt, exp_stat());
`endif

    cyc();
    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
